// File: rtl/centroid_pkg.sv
// Shared types and widths for the multi-channel centroid engine.
//   ACC_X_W / ACC_Y_W / ACC_CNT_W : default coordinate and pixel-count widths
//   SX_W / SY_W                   : coordinate sum widths, sized so a full frame cannot wrap
//   div_state_t                   : states of the shared divide sequencer
//   accum_t                       : per-channel running statistics for one frame
//   acc_init / acc_add            : empty accumulator and one-pixel update
package centroid_pkg;

    localparam int ACC_X_W   = 10;
    localparam int ACC_Y_W   = 9;
    localparam int ACC_CNT_W = 19;
    localparam int SX_W      = ACC_CNT_W + ACC_X_W;
    localparam int SY_W      = ACC_CNT_W + ACC_Y_W;

    typedef enum logic [1:0] {
        D_IDLE,
        D_X,
        D_Y,
        D_DONE
    } div_state_t;

    typedef struct packed {
        logic [ACC_CNT_W-1:0] cnt;
        logic [SX_W-1:0]      sx;
        logic [SY_W-1:0]      sy;
        logic [ACC_X_W-1:0]   xmin;
        logic [ACC_X_W-1:0]   xmax;
        logic [ACC_Y_W-1:0]   ymin;
        logic [ACC_Y_W-1:0]   ymax;
    } accum_t;

    // Minimums start at all-ones so the first detected pixel always replaces them.
    function automatic accum_t acc_init();
        accum_t a;
        a.cnt  = '0;
        a.sx   = '0;
        a.sy   = '0;
        a.xmin = '1;
        a.xmax = '0;
        a.ymin = '1;
        a.ymax = '0;
        return a;
    endfunction

    function automatic accum_t acc_add(accum_t a, logic [ACC_X_W-1:0] x, logic [ACC_Y_W-1:0] y);
        accum_t r;
        r      = a;
        r.cnt  = a.cnt + ACC_CNT_W'(1);
        r.sx   = a.sx + SX_W'(x);
        r.sy   = a.sy + SY_W'(y);
        r.xmin = (x < a.xmin) ? x : a.xmin;
        r.xmax = (x > a.xmax) ? x : a.xmax;
        r.ymin = (y < a.ymin) ? y : a.ymin;
        r.ymax = (y > a.ymax) ? y : a.ymax;
        return r;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load num/den and begin (ignored-safe only when not busy)
//   num, den   : dividend and divisor
//   busy       : division in progress
//   done       : high during the final step; quot/rem are valid in that cycle
//   quot, rem  : floor quotient and remainder
module seq_divider #(
    parameter int N_W = 29,
    parameter int D_W = 19
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] num,
    input  logic [D_W-1:0] den,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quot,
    output logic [D_W-1:0] rem
);

    localparam int C_W = $clog2(N_W + 1);

    logic [C_W-1:0] steps;
    logic [N_W-1:0] q;
    logic [D_W-1:0] r;
    logic [D_W-1:0] d;
    logic [D_W:0]   trial;
    logic           ge;

    // Partial remainder shifted left with the next dividend bit; one extra bit
    // so the compare against the divisor never overflows.
    always_comb begin
        trial = {r, q[N_W-1]};
        ge    = (trial >= {1'b0, d});
        rem   = ge ? D_W'(trial - {1'b0, d}) : trial[D_W-1:0];
        quot  = {q[N_W-2:0], ge};
    end

    assign busy = (steps != '0);
    // Outputs are combinational from the last step, so the result is usable
    // in the same cycle done is high.
    assign done = (steps == C_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps <= '0;
        end else if (start) begin
            steps <= C_W'(N_W);
        end else if (busy) begin
            steps <= steps - C_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            q <= num;
            r <= '0;
            d <= den;
        end else if (busy) begin
            q <= quot;
            r <= rem;
        end
    end

endmodule

// File: rtl/multi_channel_centroid.sv
// Per-frame centroid, bounding box and pixel count for NUM_CH detect channels.
//   iCLK, iRST        : pixel clock, asynchronous active-low reset
//   iFVAL, iDVAL      : frame valid, pixel valid
//   iX_Cont, iY_Cont  : pixel column / row
//   iDetect           : per-channel detect flag for the current pixel
//   oX_Cent, oY_Cent  : floor mean coordinate per channel (channel c at [c*W +: W])
//   oX_Min..oY_Max    : bounding box per channel (0 when the channel saw no pixels)
//   oPix_Cnt          : detected pixel count per channel
//   oCh_Val           : per-channel count >= MIN_PIX
//   oCent_Val         : one-cycle pulse when all outputs update
//   oBusy             : division in progress
//   oOverrun          : one-cycle pulse when a finished frame had to be dropped
module multi_channel_centroid
    import centroid_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int X_W     = ACC_X_W,
    parameter int Y_W     = ACC_Y_W,
    parameter int CNT_W   = ACC_CNT_W,
    parameter int MIN_PIX = 64
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iFVAL,
    input  logic                    iDVAL,
    input  logic [15:0]             iX_Cont,
    input  logic [15:0]             iY_Cont,
    input  logic [NUM_CH-1:0]       iDetect,
    output logic [NUM_CH*X_W-1:0]   oX_Cent,
    output logic [NUM_CH*Y_W-1:0]   oY_Cent,
    output logic [NUM_CH*X_W-1:0]   oX_Min,
    output logic [NUM_CH*X_W-1:0]   oX_Max,
    output logic [NUM_CH*Y_W-1:0]   oY_Min,
    output logic [NUM_CH*Y_W-1:0]   oY_Max,
    output logic [NUM_CH*CNT_W-1:0] oPix_Cnt,
    output logic [NUM_CH-1:0]       oCh_Val,
    output logic                    oCent_Val,
    output logic                    oBusy,
    output logic                    oOverrun
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic       fval_d;
    logic       armed;
    logic       fval_rise;
    logic       fval_fall;
    logic       pix_ok;
    logic       accept;
    logic       snap;
    logic       drop;

    accum_t     acc    [NUM_CH];
    accum_t     shadow [NUM_CH];
    accum_t     cur;
    logic [X_W-1:0] res_x [NUM_CH];
    logic [Y_W-1:0] res_y [NUM_CH];

    div_state_t      state, state_nxt;
    logic [CH_W-1:0] ch, ch_nxt;
    logic            issued, issued_nxt;
    logic            cap_x, cap_y, load_out;

    logic             div_start, div_busy, div_done;
    logic [SX_W-1:0]  div_num, div_quot;
    logic [CNT_W-1:0] div_rem;
    logic             unused_div;

    assign fval_rise = iFVAL & ~fval_d;
    assign fval_fall = ~iFVAL & fval_d;
    assign pix_ok    = armed & iFVAL & iDVAL & (iX_Cont < 16'(H_RES)) & (iY_Cont < 16'(V_RES));

    // A frame end can be taken while idle, or in the cycle the previous result
    // is published; anywhere else it is dropped.
    assign accept = (state == D_IDLE) || (state == D_DONE);
    assign snap   = fval_fall & armed & accept;
    assign drop   = fval_fall & armed & ~accept;

    assign cur        = shadow[ch];
    assign oBusy      = (state == D_X) || (state == D_Y);
    assign unused_div = ^{div_busy, div_rem, div_quot[SX_W-1:X_W]};

    // Arming: a frame already running when reset releases must be ignored, so
    // accumulation waits until frame-valid has been seen low once.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fval_d <= 1'b0;
            armed  <= 1'b0;
        end else begin
            fval_d <= iFVAL;
            armed  <= armed | ~iFVAL;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        accum_t base;
        logic   hit;

        // Start-of-frame clear and the first pixel's update land in the same cycle.
        assign base = fval_rise ? acc_init() : acc[c];
        assign hit  = pix_ok & iDetect[c];

        always_ff @(posedge iCLK or negedge iRST) begin
            if (!iRST) begin
                acc[c]    <= acc_init();
                shadow[c] <= acc_init();
            end else begin
                if (hit) begin
                    acc[c] <= acc_add(base, iX_Cont[X_W-1:0], iY_Cont[Y_W-1:0]);
                end else if (fval_rise) begin
                    acc[c] <= base;
                end
                if (snap) begin
                    shadow[c] <= acc[c];
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= D_IDLE;
            ch     <= '0;
            issued <= 1'b0;
        end else begin
            state  <= state_nxt;
            ch     <= ch_nxt;
            issued <= issued_nxt;
        end
    end

    // Each channel runs X then Y through the one divider; empty channels skip it.
    always_comb begin
        state_nxt  = state;
        ch_nxt     = ch;
        issued_nxt = issued;
        div_start  = 1'b0;
        div_num    = cur.sx;
        cap_x      = 1'b0;
        cap_y      = 1'b0;
        load_out   = 1'b0;
        case (state)
            D_IDLE: begin
                if (snap) begin
                    state_nxt = D_X;
                    ch_nxt    = '0;
                end
            end
            D_X: begin
                div_num = cur.sx;
                if ((cur.cnt == '0) || (issued && div_done)) begin
                    cap_x      = 1'b1;
                    issued_nxt = 1'b0;
                    state_nxt  = D_Y;
                end else if (!issued) begin
                    div_start  = 1'b1;
                    issued_nxt = 1'b1;
                end
            end
            D_Y: begin
                div_num = SX_W'(cur.sy);
                if ((cur.cnt == '0) || (issued && div_done)) begin
                    cap_y      = 1'b1;
                    issued_nxt = 1'b0;
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        state_nxt = D_DONE;
                    end else begin
                        ch_nxt    = ch + 1'b1;
                        state_nxt = D_X;
                    end
                end else if (!issued) begin
                    div_start  = 1'b1;
                    issued_nxt = 1'b1;
                end
            end
            D_DONE: begin
                load_out = 1'b1;
                if (snap) begin
                    state_nxt = D_X;
                    ch_nxt    = '0;
                end else begin
                    state_nxt = D_IDLE;
                end
            end
            default: state_nxt = D_IDLE;
        endcase
    end

    seq_divider #(
        .N_W(SX_W),
        .D_W(CNT_W)
    ) u_div (
        .clk  (iCLK),
        .rst_n(iRST),
        .start(div_start),
        .num  (div_num),
        .den  (cur.cnt),
        .busy (div_busy),
        .done (div_done),
        .quot (div_quot),
        .rem  (div_rem)
    );

    always_ff @(posedge iCLK) begin
        if (cap_x) begin
            res_x[ch] <= (cur.cnt == '0) ? '0 : div_quot[X_W-1:0];
        end
        if (cap_y) begin
            res_y[ch] <= (cur.cnt == '0) ? '0 : div_quot[Y_W-1:0];
        end
    end

    // Publish every channel together so a consumer never sees a mixed frame.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oX_Cent   <= '0;
            oY_Cent   <= '0;
            oX_Min    <= '0;
            oX_Max    <= '0;
            oY_Min    <= '0;
            oY_Max    <= '0;
            oPix_Cnt  <= '0;
            oCh_Val   <= '0;
            oCent_Val <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            oCent_Val <= load_out;
            oOverrun  <= drop;
            if (load_out) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    oX_Cent[c*X_W +: X_W]    <= res_x[c];
                    oY_Cent[c*Y_W +: Y_W]    <= res_y[c];
                    oX_Min[c*X_W +: X_W]     <= (shadow[c].cnt == '0) ? '0 : shadow[c].xmin;
                    oX_Max[c*X_W +: X_W]     <= (shadow[c].cnt == '0) ? '0 : shadow[c].xmax;
                    oY_Min[c*Y_W +: Y_W]     <= (shadow[c].cnt == '0) ? '0 : shadow[c].ymin;
                    oY_Max[c*Y_W +: Y_W]     <= (shadow[c].cnt == '0) ? '0 : shadow[c].ymax;
                    oPix_Cnt[c*CNT_W +: CNT_W] <= shadow[c].cnt;
                    oCh_Val[c]               <= (shadow[c].cnt >= CNT_W'(MIN_PIX));
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_centroid.sv
// Directed bench for multi_channel_centroid. A reduced 128x64 raster keeps a
// full frame short; per-frame expectations come from plain-arithmetic
// statistics of the driven pixels, with literal pins on selected results.
module tb_multi_channel_centroid;

    localparam int NUM_CH  = 4;
    localparam int H_RES   = 128;
    localparam int V_RES   = 64;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int CNT_W   = 19;
    localparam int MIN_PIX = 64;
    localparam int LAT_MAX = NUM_CH * ((CNT_W + X_W) + (CNT_W + Y_W) + 4) + 2;

    logic                    iCLK, iRST, iFVAL, iDVAL;
    logic [15:0]             iX_Cont, iY_Cont;
    logic [NUM_CH-1:0]       iDetect;
    logic [NUM_CH*X_W-1:0]   oX_Cent, oX_Min, oX_Max;
    logic [NUM_CH*Y_W-1:0]   oY_Cent, oY_Min, oY_Max;
    logic [NUM_CH*CNT_W-1:0] oPix_Cnt;
    logic [NUM_CH-1:0]       oCh_Val;
    logic                    oCent_Val, oBusy, oOverrun;

    multi_channel_centroid #(
        .NUM_CH(NUM_CH), .H_RES(H_RES), .V_RES(V_RES),
        .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .MIN_PIX(MIN_PIX)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL),
        .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iDetect(iDetect),
        .oX_Cent(oX_Cent), .oY_Cent(oY_Cent), .oX_Min(oX_Min), .oX_Max(oX_Max),
        .oY_Min(oY_Min), .oY_Max(oY_Max), .oPix_Cnt(oPix_Cnt), .oCh_Val(oCh_Val),
        .oCent_Val(oCent_Val), .oBusy(oBusy), .oOverrun(oOverrun)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [NUM_CH*X_W-1:0]   cx;
        logic [NUM_CH*Y_W-1:0]   cy;
        logic [NUM_CH*X_W-1:0]   xmin;
        logic [NUM_CH*X_W-1:0]   xmax;
        logic [NUM_CH*Y_W-1:0]   ymin;
        logic [NUM_CH*Y_W-1:0]   ymax;
        logic [NUM_CH*CNT_W-1:0] cnt;
        logic [NUM_CH-1:0]       chv;
        logic [31:0]             t_fall;
    } res_t;

    res_t   exp_q[$];
    res_t   cmp_r;
    longint m_cnt [NUM_CH];
    longint m_sx  [NUM_CH];
    longint m_sy  [NUM_CH];
    int     m_xmin[NUM_CH], m_xmax[NUM_CH], m_ymin[NUM_CH], m_ymax[NUM_CH];
    bit     m_armed = 0;
    int     exp_ovr = 0, seen_ovr = 0;
    int     total = 0, bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_sx[c] = 0; m_sy[c] = 0;
            m_xmin[c] = 1 << 30; m_xmax[c] = -1;
            m_ymin[c] = 1 << 30; m_ymax[c] = -1;
        end
    endtask

    task automatic idle(input int n);
        iFVAL = 1'b0; iDVAL = 1'b0; iDetect = '0;
        repeat (n) tick();
        if (iRST) m_armed = 1;
    endtask

    task automatic frame_begin();
        iFVAL = 1'b1; iDVAL = 1'b0; iDetect = '0;
        tick();
        model_clear();
    endtask

    task automatic pixel(input int x, input int y, input bit dv, input logic [NUM_CH-1:0] det);
        iFVAL = 1'b1; iDVAL = dv; iX_Cont = 16'(x); iY_Cont = 16'(y); iDetect = det;
        tick();
        if (m_armed && dv && x < H_RES && y < V_RES) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (det[c]) begin
                    m_cnt[c]++; m_sx[c] += x; m_sy[c] += y;
                    if (x < m_xmin[c]) m_xmin[c] = x;
                    if (x > m_xmax[c]) m_xmax[c] = x;
                    if (y < m_ymin[c]) m_ymin[c] = y;
                    if (y > m_ymax[c]) m_ymax[c] = y;
                end
            end
        end
    endtask

    // A frame ending while a previous result is still outstanding is lost.
    task automatic frame_end();
        res_t r;
        iFVAL = 1'b0; iDVAL = 1'b0; iDetect = '0;
        tick();
        if (m_armed) begin
            if (exp_q.size() != 0) begin
                exp_ovr++;
            end else begin
                r = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (m_cnt[c] != 0) begin
                        r.cx[c*X_W +: X_W]   = X_W'(m_sx[c] / m_cnt[c]);
                        r.cy[c*Y_W +: Y_W]   = Y_W'(m_sy[c] / m_cnt[c]);
                        r.xmin[c*X_W +: X_W] = X_W'(m_xmin[c]);
                        r.xmax[c*X_W +: X_W] = X_W'(m_xmax[c]);
                        r.ymin[c*Y_W +: Y_W] = Y_W'(m_ymin[c]);
                        r.ymax[c*Y_W +: Y_W] = Y_W'(m_ymax[c]);
                    end
                    r.cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
                    r.chv[c] = (m_cnt[c] >= MIN_PIX);
                end
                r.t_fall = cyc;
                exp_q.push_back(r);
            end
        end
        m_armed = 1;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < LAT_MAX + 50) begin
            tick();
            k++;
        end
        check("result_arrived", exp_q.size(), 0);
        exp_q.delete();
        check("busy_after_result", oBusy, 1'b0);
    endtask

    always @(negedge iCLK) begin
        if (iRST === 1'b1) begin
            if (oOverrun === 1'b1) seen_ovr++;
            if (oCent_Val === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cent_val: got 1 want 0 (cycle %0d)", cyc);
                end else begin
                    cmp_r = exp_q.pop_front();
                    check("cent_x", oX_Cent, cmp_r.cx);
                    check("cent_y", oY_Cent, cmp_r.cy);
                    check("x_min", oX_Min, cmp_r.xmin);
                    check("x_max", oX_Max, cmp_r.xmax);
                    check("y_min", oY_Min, cmp_r.ymin);
                    check("y_max", oY_Max, cmp_r.ymax);
                    check("pix_cnt", oPix_Cnt, cmp_r.cnt);
                    check("ch_val", oCh_Val, cmp_r.chv);
                    check("latency_within_bound", (cyc - int'(cmp_r.t_fall)) <= LAT_MAX, 1'b1);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        iRST = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0;
        iX_Cont = '0; iY_Cont = '0; iDetect = '0;
        model_clear();
        repeat (3) tick();
        check("reset_cent_x", oX_Cent, '0);
        check("reset_pix_cnt", oPix_Cnt, '0);
        check("reset_flags", {oCent_Val, oBusy, oOverrun, oCh_Val}, '0);
        iRST = 1'b1;
        idle(4);
        check("idle_after_reset", {oCent_Val, oBusy, oOverrun}, '0);

        // Single detected pixel on channel 0.
        frame_begin();
        pixel(10, 3, 1'b1, 4'b0000);
        pixel(100, 50, 1'b1, 4'b0001);
        pixel(101, 50, 1'b1, 4'b0000);
        frame_end();
        drain();
        check("t1_cx0", oX_Cent[X_W-1:0], 100);
        check("t1_cy0", oY_Cent[Y_W-1:0], 50);
        check("t1_bbox0", {oX_Min[X_W-1:0], oX_Max[X_W-1:0], oY_Min[Y_W-1:0], oY_Max[Y_W-1:0]},
              {10'd100, 10'd100, 9'd50, 9'd50});
        check("t1_cnt0", oPix_Cnt[CNT_W-1:0], 1);
        check("t1_chval0", oCh_Val[0], 1'b0);
        idle(5);

        // Full raster on ch1, 8x8 block on ch0, 32-pixel run on ch2, nothing on ch3.
        frame_begin();
        for (int y = 0; y < V_RES; y++) begin
            for (int x = 0; x < H_RES; x++) begin
                logic [NUM_CH-1:0] d;
                d    = '0;
                d[1] = 1'b1;
                d[0] = (x < 8) && (y < 8);
                d[2] = (y == 10) && (x >= 20) && (x < 52);
                pixel(x, y, 1'b1, d);
            end
        end
        frame_end();
        drain();
        check("t2_cx1", oX_Cent[X_W +: X_W], 63);
        check("t2_cy1", oY_Cent[Y_W +: Y_W], 31);
        check("t2_cnt1", oPix_Cnt[CNT_W +: CNT_W], 8192);
        check("t2_bbox1", {oX_Min[X_W +: X_W], oX_Max[X_W +: X_W], oY_Min[Y_W +: Y_W], oY_Max[Y_W +: Y_W]},
              {10'd0, 10'd127, 9'd0, 9'd63});
        check("t2_chval", oCh_Val, 4'b0011);
        check("t2_cnt2", oPix_Cnt[2*CNT_W +: CNT_W], 32);
        check("t2_cx2", oX_Cent[2*X_W +: X_W], 35);
        check("t3_ch3_zero", {oX_Cent[3*X_W +: X_W], oY_Cent[3*Y_W +: Y_W], oX_Min[3*X_W +: X_W],
              oY_Min[3*Y_W +: Y_W], oPix_Cnt[3*CNT_W +: CNT_W]}, '0);
        idle(5);

        // Pixels gated by DVAL and the active-area limits.
        frame_begin();
        pixel(5, 5, 1'b1, 4'b1000);
        pixel(6, 6, 1'b0, 4'b1000);
        pixel(128, 7, 1'b1, 4'b1000);
        pixel(7, 64, 1'b1, 4'b1000);
        pixel(200, 200, 1'b1, 4'b1000);
        pixel(127, 63, 1'b1, 4'b1000);
        frame_end();
        drain();
        check("t4_cnt3", oPix_Cnt[3*CNT_W +: CNT_W], 2);
        check("t4_cent3", {oX_Cent[3*X_W +: X_W], oY_Cent[3*Y_W +: Y_W]}, {10'd66, 9'd34});
        idle(5);

        // Reset mid-frame, released while the frame is still valid.
        frame_begin();
        for (int i = 0; i < 10; i++) pixel(10 + i, 2, 1'b1, 4'b0001);
        iRST = 1'b0;
        repeat (3) tick();
        m_armed = 0;
        exp_q.delete();
        check("t5_reset_outputs", {oX_Cent, oPix_Cnt, oCh_Val, oCent_Val, oBusy}, '0);
        iRST = 1'b1;
        for (int i = 0; i < 10; i++) pixel(30 + i, 3, 1'b1, 4'b0001);
        frame_end();
        idle(LAT_MAX + 20);
        frame_begin();
        for (int y = 4; y < 6; y++)
            for (int x = 20; x < 30; x++) pixel(x, y, 1'b1, 4'b0101);
        frame_end();
        drain();
        check("t5_cnt0", oPix_Cnt[CNT_W-1:0], 20);
        idle(5);

        // Short blanking: second frame ends while the first is still dividing.
        frame_begin();
        for (int x = 40; x < 60; x++) pixel(x, 30, 1'b1, 4'b0010);
        frame_end();
        idle(20);
        check("t6_busy", oBusy, 1'b1);
        frame_begin();
        for (int x = 0; x < 10; x++) pixel(x, 1, 1'b1, 4'b0010);
        frame_end();
        drain();
        check("t6_first_frame_cx1", oX_Cent[X_W +: X_W], 49);
        idle(LAT_MAX + 20);
        check("t6_overrun_seen", seen_ovr, exp_ovr);
        check("t6_overrun_count", seen_ovr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
